// File: rtl/tinyml_source_common_be_dual_port_ram_if.sv
// Port bundle for the tinyml byte-enable dual-port RAM.
// master: the client side (DMA / compute engine pair).
// slave: the RAM itself.
interface tinyml_source_common_be_dual_port_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  a_en;
    logic [NB-1:0]         a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_din;
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_dout_valid;

    logic                  b_en;
    logic [NB-1:0]         b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_din;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_dout_valid;

    logic                  ready;
    logic                  collision;
    logic [15:0]           collision_cnt;

    modport master (
        output a_en, a_we, a_addr, a_din,
        output b_en, b_we, b_addr, b_din,
        input  a_dout, a_dout_valid, b_dout, b_dout_valid,
        input  ready, collision, collision_cnt
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din,
        input  b_en, b_we, b_addr, b_din,
        output a_dout, a_dout_valid, b_dout, b_dout_valid,
        output ready, collision, collision_cnt
    );
endinterface

// File: rtl/tinyml_source_common_be_dual_port_ram.sv
// Single-clock true dual-port RAM with byte write enables, per-port read
// valid, optional output register, deterministic same-address collision
// handling and a post-reset clear sweep.
// Optional feature macro: TINYML_RAM_COLLISION_STATS_EN enables the saturating
// collision counter; otherwise collision_cnt is tied to zero.
module tinyml_source_common_be_dual_port_ram #(
    parameter int              DATA_WIDTH     = 32,
    parameter int              BYTE_WIDTH     = 8,
    parameter int              ADDR_WIDTH     = 10,
    parameter string           WRITE_MODE_A   = "READ_FIRST",
    parameter string           WRITE_MODE_B   = "READ_FIRST",
    parameter string           OUTPUT_REG_A   = "FALSE",
    parameter string           OUTPUT_REG_B   = "FALSE",
    parameter string           WR_PRIORITY    = "PORT_A",
    parameter int              CLEAR_ON_RESET = 1,
    parameter [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic clk,
    input logic rst_n,
    tinyml_source_common_be_dual_port_ram_if.slave bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Higher-priority port is written last so its bytes win on overlap.
    localparam int HI    = (WR_PRIORITY == "PORT_B") ? 1 : 0;
    localparam int LO    = 1 - HI;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]                 en;
    logic [1:0][NB-1:0]         we;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] din;
    logic [1:0][DATA_WIDTH-1:0] dout;
    logic [1:0]                 dout_valid;
    logic [1:0]                 access;
    logic                       ready;
    logic                       coll_now;
    logic                       collision_reg;

    assign en   = {bus.b_en,   bus.a_en};
    assign we   = {bus.b_we,   bus.a_we};
    assign addr = {bus.b_addr, bus.a_addr};
    assign din  = {bus.b_din,  bus.a_din};

    assign bus.a_dout       = dout[0];
    assign bus.b_dout       = dout[1];
    assign bus.a_dout_valid = dout_valid[0];
    assign bus.b_dout_valid = dout_valid[1];
    assign bus.ready        = ready;
    assign bus.collision    = collision_reg;

    assign ready    = (state_reg == ST_READY);
    assign access   = en & {ready, ready};
    assign coll_now = access[0] && access[1] && (addr[0] == addr[1])
                      && ((|we[0]) || (|we[1]));

    // Clear-sweep state and address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // Sweep walks every address once, then hands over to normal access.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        if (state_reg == ST_CLEAR) begin
            clr_addr_next = clr_addr_reg + 1'b1;
            if (&clr_addr_reg) begin
                state_next = ST_READY;
            end
        end
    end

    // Memory writes: sweep pattern, or byte-granular port writes with the
    // priority port's bytes landing last on a shared address.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_reg == ST_CLEAR) begin
                mem[clr_addr_reg] <= CLEAR_VALUE;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (access[LO] && we[LO][i])
                        mem[addr[LO]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[LO][i*BYTE_WIDTH +: BYTE_WIDTH];
                    if (access[HI] && we[HI][i])
                        mem[addr[HI]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[HI][i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Per-port read path. The raw word is always the pre-write contents;
    // write-first ports overlay their own din bytes after the RAM register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam string MODE = (gi == 0) ? WRITE_MODE_A : WRITE_MODE_B;
        localparam string OREG = (gi == 0) ? OUTPUT_REG_A : OUTPUT_REG_B;
        localparam bit    WF   = (MODE == "WRITE_FIRST");
        localparam bit    NC   = (MODE == "NO_CHANGE");

        logic                  produce;
        logic                  vld_reg;
        logic [DATA_WIDTH-1:0] raw_reg;
        logic [DATA_WIDTH-1:0] din_reg;
        logic [NB-1:0]         mask_reg;
        logic [DATA_WIDTH-1:0] mux_word;

        // A no-change port that writes produces no result and keeps dout.
        assign produce = access[gi] && !(NC && (|we[gi]));

        // Registered RAM read plus the write-first overlay controls.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_reg  <= 1'b0;
                raw_reg  <= '0;
                din_reg  <= '0;
                mask_reg <= '0;
            end else begin
                vld_reg <= produce;
                if (produce) begin
                    raw_reg  <= mem[addr[gi]];
                    din_reg  <= din[gi];
                    mask_reg <= WF ? we[gi] : {NB{1'b0}};
                end
            end
        end

        for (genvar bi = 0; bi < NB; bi++) begin : g_byte
            assign mux_word[bi*BYTE_WIDTH +: BYTE_WIDTH] = mask_reg[bi]
                ? din_reg[bi*BYTE_WIDTH +: BYTE_WIDTH]
                : raw_reg[bi*BYTE_WIDTH +: BYTE_WIDTH];
        end

        if (OREG == "TRUE") begin : g_oreg
            logic [DATA_WIDTH-1:0] out_reg;
            logic                  out_vld_reg;

            // Extra output stage; holds its value between results.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_reg     <= '0;
                    out_vld_reg <= 1'b0;
                end else begin
                    out_vld_reg <= vld_reg;
                    if (vld_reg) begin
                        out_reg <= mux_word;
                    end
                end
            end

            assign dout[gi]       = out_reg;
            assign dout_valid[gi] = out_vld_reg;
        end else begin : g_noreg
            assign dout[gi]       = mux_word;
            assign dout_valid[gi] = vld_reg;
        end
    end

    // Collision pulse, one cycle after the conflicting accesses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= coll_now;
        end
    end

`ifdef TINYML_RAM_COLLISION_STATS_EN
    logic [15:0] coll_cnt_reg;

    // Saturating count, updated on the same edge that raises the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_cnt_reg <= '0;
        end else if (coll_now && (coll_cnt_reg != 16'hFFFF)) begin
            coll_cnt_reg <= coll_cnt_reg + 16'd1;
        end
    end

    assign bus.collision_cnt = coll_cnt_reg;
`else
    assign bus.collision_cnt = 16'h0000;
`endif
endmodule
